fir_out_requant: RTL and testbench

Output re-quantisation stage that sits directly downstream of the FIR filter. It takes the full-precision FIR product/sum word, applies a programmable rounding right-shift, and saturates the result to the DSP output width. It buffers samples behind a valid/ready handshake with fully registered ready, so the FIR output never has a combinational path to the external sink. It also keeps a sticky saturation flag and a saturation event counter for the memory map.

---
 rtl/pak_dsp_pkg.sv | 18 +
 rtl/fir_out_requant_if.sv | 28 ++
 rtl/skid_fifo2.sv | 53 +++++
 rtl/fir_out_requant.sv | 105 ++++++++++
 tb/tb_fir_out_requant.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/pak_dsp_pkg.sv
// Shared DSP constants and helpers for the FIR datapath and its output stages.
package pak_dsp_pkg;

  localparam int DATA_WIDTH           = 16;
  localparam int OUTPUT_WORD_SIZE_FIR = 2*DATA_WIDTH+5;

  typedef logic [1:0] fifo_count_t;

  // Two's-complement clamp limits for a signed word of the given width.
  function automatic logic signed [63:0] sat_max(input int width);
    return (64'sd1 <<< (width-1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int width);
    return -(64'sd1 <<< (width-1));
  endfunction

endpackage

// File: rtl/fir_out_requant_if.sv
// Source and sink valid/ready channels of the FIR output re-quantiser.
interface fir_out_requant_if
  import pak_dsp_pkg::*;
#(
  parameter int IN_WIDTH  = OUTPUT_WORD_SIZE_FIR,
  parameter int OUT_WIDTH = DATA_WIDTH
);

  logic signed [IN_WIDTH-1:0]  src_data_in;
  logic                        src_valid_in;
  logic                        src_ready_out;
  logic signed [OUT_WIDTH-1:0] dst_data_out;
  logic                        dst_valid_out;
  logic                        dst_ready_in;

  // The re-quantiser block itself.
  modport slave (
    input  src_data_in, src_valid_in, dst_ready_in,
    output src_ready_out, dst_data_out, dst_valid_out
  );

  // The FIR source and the downstream sink seen together.
  modport master (
    output src_data_in, src_valid_in, dst_ready_in,
    input  src_ready_out, dst_data_out, dst_valid_out
  );

endinterface

// File: rtl/skid_fifo2.sv
// Two-entry registered FIFO; the head register drives the output directly.
module skid_fifo2
  import pak_dsp_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output fifo_count_t      count
);

  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] tail;

  // Simultaneous push/pop keeps the count; when full the tail shifts up into the head.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) head <= din;
          else               tail <= din;
          count <= count + 2'd1;
        end
        2'b01: begin
          head  <= tail;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd2) begin
            head <= tail;
            tail <= din;
          end else begin
            head <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign dout  = head;
  assign valid = (count != 2'd0);

endmodule

// File: rtl/fir_out_requant.sv
// Rounding right-shift and saturation of the FIR output word, buffered behind registered-ready handshakes.
module fir_out_requant
  import pak_dsp_pkg::*;
#(
  parameter int IN_WIDTH      = OUTPUT_WORD_SIZE_FIR,
  parameter int OUT_WIDTH     = DATA_WIDTH,
  parameter int SHIFT_WIDTH   = 5,
  parameter int SAT_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     arst_n,
  input  logic [SHIFT_WIDTH-1:0]   shift,
  input  logic                     round_en,
  input  logic                     sat_clear,
  fir_out_requant_if.slave         io,
  output logic                     sat_flag,
  output logic [SAT_CNT_WIDTH-1:0] sat_count
);

  localparam logic signed [63:0]       SAT_HI64 = sat_max(OUT_WIDTH);
  localparam logic signed [63:0]       SAT_LO64 = sat_min(OUT_WIDTH);
  localparam logic signed [IN_WIDTH:0] SAT_HI   = SAT_HI64[IN_WIDTH:0];
  localparam logic signed [IN_WIDTH:0] SAT_LO   = SAT_LO64[IN_WIDTH:0];

  logic signed [IN_WIDTH:0]    rnd;
  logic signed [IN_WIDTH:0]    sum;
  logic signed [IN_WIDTH:0]    shifted;
  logic signed [OUT_WIDTH-1:0] res;
  logic                        sat;

  logic                        a_valid;
  logic signed [OUT_WIDTH-1:0] a_data;
  logic                        ready;
  logic                        accept;
  logic                        push;
  logic                        pop;
  logic                        head_valid;
  logic [OUT_WIDTH-1:0]        head_data;
  fifo_count_t                 fifo_count;

  // One extra bit of headroom keeps the rounding offset from overflowing the sum.
  always_comb begin
    rnd = '0;
    if (round_en && shift != '0)
      rnd = {{IN_WIDTH{1'b0}}, 1'b1} << (shift - SHIFT_WIDTH'(1));
    sum     = {io.src_data_in[IN_WIDTH-1], io.src_data_in} + rnd;
    shifted = sum >>> shift;
    sat     = 1'b1;
    if (shifted > SAT_HI) begin
      res = SAT_HI[OUT_WIDTH-1:0];
    end else if (shifted < SAT_LO) begin
      res = SAT_LO[OUT_WIDTH-1:0];
    end else begin
      res = shifted[OUT_WIDTH-1:0];
      sat = 1'b0;
    end
  end

  assign ready  = !(a_valid && fifo_count == 2'd2);
  assign accept = io.src_valid_in && ready;
  assign pop    = head_valid && io.dst_ready_in;
  assign push   = a_valid && (fifo_count != 2'd2 || pop);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      a_valid <= 1'b0;
      a_data  <= '0;
    end else if (accept) begin
      a_valid <= 1'b1;
      a_data  <= res;
    end else if (push) begin
      a_valid <= 1'b0;
    end
  end

  skid_fifo2 #(.WIDTH(OUT_WIDTH)) u_fifo (
    .clk    (clk),
    .arst_n (arst_n),
    .push   (push),
    .pop    (pop),
    .din    (a_data),
    .dout   (head_data),
    .valid  (head_valid),
    .count  (fifo_count)
  );

  assign io.src_ready_out = ready;
  assign io.dst_valid_out = head_valid;
  assign io.dst_data_out  = head_data;

  // Statistics follow accepted samples, so downstream stalls never delay them.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      sat_flag  <= 1'b0;
      sat_count <= '0;
    end else if (sat_clear) begin
      sat_flag  <= 1'b0;
      sat_count <= '0;
    end else if (accept && sat) begin
      sat_flag <= 1'b1;
      if (sat_count != '1) sat_count <= sat_count + SAT_CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_fir_out_requant.sv
// Directed scenario bench for fir_out_requant with hand-computed expectations.
module tb_fir_out_requant;
  import pak_dsp_pkg::*;

  localparam int IW = 37;
  localparam int OW = 16;
  localparam int SW = 5;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          arst_n = 1'b0;
  logic [SW-1:0] shift;
  logic          round_en;
  logic          sat_clear;
  logic          sat_flag;
  logic [CW-1:0] sat_count;

  int total = 0;
  int bad   = 0;

  fir_out_requant_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) bus ();

  fir_out_requant #(
    .IN_WIDTH(IW), .OUT_WIDTH(OW), .SHIFT_WIDTH(SW), .SAT_CNT_WIDTH(CW)
  ) dut (
    .clk       (clk),
    .arst_n    (arst_n),
    .shift     (shift),
    .round_en  (round_en),
    .sat_clear (sat_clear),
    .io        (bus.slave),
    .sat_flag  (sat_flag),
    .sat_count (sat_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    shift = '0; round_en = 1'b0; sat_clear = 1'b0;
    bus.src_data_in = '0; bus.src_valid_in = 1'b0; bus.dst_ready_in = 1'b1;
    #3;
    total++; if (bus.dst_valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus.dst_valid_out); end
    total++; if (bus.dst_data_out !== 16'sd0) begin bad++; $display("FAIL reset_data: got %0d want 0", bus.dst_data_out); end
    total++; if (bus.src_ready_out !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", bus.src_ready_out); end
    total++; if (sat_flag !== 1'b0) begin bad++; $display("FAIL reset_flag: got %b want 0", sat_flag); end
    total++; if (sat_count !== 16'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", sat_count); end
    #9 arst_n = 1'b1;
    step();
  endtask

  task automatic test_round();
    shift = 5'd15; round_en = 1'b1; bus.dst_ready_in = 1'b1;
    bus.src_data_in = 37'sd16384; bus.src_valid_in = 1'b1;
    step();
    bus.src_valid_in = 1'b0;
    total++; if (bus.dst_valid_out !== 1'b0) begin bad++; $display("FAIL round_early: got valid %b want 0", bus.dst_valid_out); end
    step();
    total++; if (bus.dst_valid_out !== 1'b1 || bus.dst_data_out !== 16'sd1) begin bad++; $display("FAIL round_out: got v=%b d=%0d want v=1 d=1", bus.dst_valid_out, bus.dst_data_out); end
    total++; if (sat_flag !== 1'b0) begin bad++; $display("FAIL round_flag: got %b want 0", sat_flag); end
    step();
    total++; if (bus.dst_valid_out !== 1'b0) begin bad++; $display("FAIL round_drain: got valid %b want 0", bus.dst_valid_out); end
  endtask

  task automatic test_truncation();
    shift = 5'd15; bus.dst_ready_in = 1'b1;
    bus.src_data_in = -37'sd16384; round_en = 1'b0; bus.src_valid_in = 1'b1;
    step();
    round_en = 1'b1;
    step();
    bus.src_valid_in = 1'b0;
    total++; if (bus.dst_valid_out !== 1'b1 || bus.dst_data_out !== -16'sd1) begin bad++; $display("FAIL trunc_floor: got v=%b d=%0d want v=1 d=-1", bus.dst_valid_out, bus.dst_data_out); end
    step();
    total++; if (bus.dst_valid_out !== 1'b1 || bus.dst_data_out !== 16'sd0) begin bad++; $display("FAIL trunc_round: got v=%b d=%0d want v=1 d=0", bus.dst_valid_out, bus.dst_data_out); end
    step();
  endtask

  task automatic test_saturation();
    shift = 5'd15; round_en = 1'b1; bus.dst_ready_in = 1'b1; sat_clear = 1'b0;
    bus.src_data_in = 37'sd2147483648; bus.src_valid_in = 1'b1;
    step();
    bus.src_data_in = -37'sd2147483648;
    step();
    bus.src_valid_in = 1'b0;
    total++; if (bus.dst_data_out !== 16'sd32767) begin bad++; $display("FAIL sat_pos: got %0d want 32767", bus.dst_data_out); end
    step();
    total++; if (bus.dst_data_out !== -16'sd32768) begin bad++; $display("FAIL sat_neg: got %0d want -32768", bus.dst_data_out); end
    total++; if (sat_count !== 16'd2) begin bad++; $display("FAIL sat_count2: got %0d want 2", sat_count); end
    total++; if (sat_flag !== 1'b1) begin bad++; $display("FAIL sat_flag1: got %b want 1", sat_flag); end
    sat_clear = 1'b1; bus.src_data_in = 37'sd2147483648; bus.src_valid_in = 1'b1;
    step();
    sat_clear = 1'b0; bus.src_valid_in = 1'b0;
    total++; if (sat_count !== 16'd0) begin bad++; $display("FAIL clear_count: got %0d want 0", sat_count); end
    total++; if (sat_flag !== 1'b0) begin bad++; $display("FAIL clear_flag: got %b want 0", sat_flag); end
    step();
    total++; if (bus.dst_valid_out !== 1'b1 || bus.dst_data_out !== 16'sd32767) begin bad++; $display("FAIL clear_sample: got v=%b d=%0d want v=1 d=32767", bus.dst_valid_out, bus.dst_data_out); end
    step();
    total++; if (sat_count !== 16'd0) begin bad++; $display("FAIL clear_hold: got %0d want 0", sat_count); end
  endtask

  task automatic test_backpressure();
    int sent = 0;
    int got = 0;
    logic signed [OW-1:0] outv [5];
    logic will_acc;
    logic will_pop;
    shift = 5'd0; round_en = 1'b0; bus.dst_ready_in = 1'b0;
    bus.src_data_in = 37'sd1; bus.src_valid_in = 1'b1;
    for (int i = 0; i < 36; i++) begin
      if (i == 6) begin
        total++; if (sent != 3) begin bad++; $display("FAIL bp_accepted: got %0d want 3", sent); end
        total++; if (bus.src_ready_out !== 1'b0) begin bad++; $display("FAIL bp_ready: got %b want 0", bus.src_ready_out); end
        total++; if (bus.dst_valid_out !== 1'b1 || bus.dst_data_out !== 16'sd1) begin bad++; $display("FAIL bp_stable: got v=%b d=%0d want v=1 d=1", bus.dst_valid_out, bus.dst_data_out); end
        bus.dst_ready_in = 1'b1;
      end
      if (got == 5) break;
      will_acc = bus.src_valid_in && bus.src_ready_out;
      will_pop = bus.dst_valid_out && bus.dst_ready_in;
      if (will_pop && got < 5) outv[got] = bus.dst_data_out;
      step();
      if (will_acc) sent++;
      if (will_pop) got++;
      if (sent < 5) begin
        bus.src_valid_in = 1'b1;
        bus.src_data_in  = 37'(sent + 1);
      end else begin
        bus.src_valid_in = 1'b0;
      end
    end
    bus.src_valid_in = 1'b0;
    total++; if (got != 5) begin bad++; $display("FAIL bp_outputs: got %0d want 5", got); end
    for (int k = 0; k < 5; k++) begin
      if (k < got) begin
        total++; if (outv[k] !== 16'(k + 1)) begin bad++; $display("FAIL bp_order%0d: got %0d want %0d", k, outv[k], k + 1); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic signed [OW-1:0] exp_v;
    shift = 5'd0; round_en = 1'b0; bus.dst_ready_in = 1'b1;
    for (int i = 0; i < 11; i++) begin
      if (i >= 2 && i <= 9) begin
        exp_v = 16'(8 + i);
        total++; if (bus.dst_valid_out !== 1'b1 || bus.dst_data_out !== exp_v) begin bad++; $display("FAIL b2b_out%0d: got v=%b d=%0d want v=1 d=%0d", i, bus.dst_valid_out, bus.dst_data_out, exp_v); end
      end else begin
        total++; if (bus.dst_valid_out !== 1'b0) begin bad++; $display("FAIL b2b_idle%0d: got v=%b want 0", i, bus.dst_valid_out); end
      end
      if (i < 8) begin
        total++; if (bus.src_ready_out !== 1'b1) begin bad++; $display("FAIL b2b_ready%0d: got %b want 1", i, bus.src_ready_out); end
        bus.src_valid_in = 1'b1;
        bus.src_data_in  = 37'(10 + i);
      end else begin
        bus.src_valid_in = 1'b0;
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    int stale = 0;
    shift = 5'd0; round_en = 1'b0; bus.dst_ready_in = 1'b0; sat_clear = 1'b0;
    bus.src_valid_in = 1'b1;
    bus.src_data_in = 37'sd40000;
    step();
    bus.src_data_in = 37'sd8;
    step();
    bus.src_data_in = 37'sd9;
    step();
    bus.src_valid_in = 1'b0;
    total++; if (bus.src_ready_out !== 1'b0) begin bad++; $display("FAIL mid_full: got ready %b want 0", bus.src_ready_out); end
    total++; if (sat_count !== 16'd1) begin bad++; $display("FAIL mid_count: got %0d want 1", sat_count); end
    #2 arst_n = 1'b0;
    #1;
    total++; if (bus.dst_valid_out !== 1'b0) begin bad++; $display("FAIL mid_valid: got %b want 0", bus.dst_valid_out); end
    total++; if (bus.src_ready_out !== 1'b1) begin bad++; $display("FAIL mid_ready: got %b want 1", bus.src_ready_out); end
    total++; if (sat_count !== 16'd0 || sat_flag !== 1'b0) begin bad++; $display("FAIL mid_stats: got count=%0d flag=%b want 0 0", sat_count, sat_flag); end
    #2 arst_n = 1'b1;
    bus.dst_ready_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (bus.dst_valid_out !== 1'b0) stale++;
    end
    total++; if (stale != 0) begin bad++; $display("FAIL mid_stale: got %0d valid cycles want 0", stale); end
    bus.src_data_in = 37'sd42; bus.src_valid_in = 1'b1;
    step();
    bus.src_valid_in = 1'b0;
    step();
    total++; if (bus.dst_valid_out !== 1'b1 || bus.dst_data_out !== 16'sd42) begin bad++; $display("FAIL mid_after: got v=%b d=%0d want v=1 d=42", bus.dst_valid_out, bus.dst_data_out); end
    step();
  endtask

  initial begin
    test_reset();
    test_round();
    test_truncation();
    test_saturation();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
